// File: rtl/bpd_upd_ctrl.sv
// Write-port controller for the tournament predictor tables: init sweep after reset/init_start,
// then retire-time updates drained in order from a small FIFO, one registered write per cycle.
module bpd_upd_ctrl #(
  parameter int DEPTH        = 8,
  parameter int PHT_IDX_W    = 12,
  parameter int BHT_IDX_W    = 10,
  parameter int INIT_ENTRIES = 4096
)(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       upd_valid_i,
  output logic                       upd_ready_o,
  input  logic [63:0]                upd_pc_i,
  input  logic                       upd_brdir_i,
  input  logic                       upd_ch_we_i,
  input  logic                       upd_ch_brdir_i,
  input  logic                       hold_i,
  input  logic                       init_start_i,
  output logic                       tbl_we_o,
  output logic                       tbl_init_o,
  output logic [PHT_IDX_W-1:0]       pht_wt_index_o,
  output logic [BHT_IDX_W-1:0]       bht_wt_index_o,
  output logic                       bht_brdir_o,
  output logic                       ch_we_o,
  output logic                       ch_brdir_o,
  output logic                       init_done_o,
  output logic [$clog2(DEPTH):0]     fifo_cnt_o
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int MW  = (PHT_IDX_W > BHT_IDX_W) ? PHT_IDX_W : BHT_IDX_W;
  localparam int IW0 = $clog2(INIT_ENTRIES);
  localparam int IW  = (IW0 > MW) ? IW0 : MW;
  localparam logic [IW-1:0] LAST_IDX = IW'(INIT_ENTRIES - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                r_state;
  logic [IW-1:0]         r_init_idx;
  logic                  r_init_done;
  logic [AW-1:0]         r_wp, r_rp;
  logic [CW-1:0]         r_cnt;
  logic [PHT_IDX_W-1:0]  r_pht_q [DEPTH];
  logic [BHT_IDX_W-1:0]  r_bht_q [DEPTH];
  logic [DEPTH-1:0]      r_dir_q, r_chwe_q, r_chdir_q;

  logic w_full, w_push, w_pop, w_unused;

  assign w_full      = (r_cnt == CW'(DEPTH));
  assign w_push      = upd_valid_i && !w_full && !init_start_i;
  // Issue waits one cycle past the sweep so init_done_o is visible before the first update write.
  assign w_pop       = (r_state == S_RUN) && r_init_done && !hold_i && (r_cnt != '0);
  assign upd_ready_o = !w_full;
  assign fifo_cnt_o  = r_cnt;
  assign init_done_o = r_init_done;
  assign w_unused    = ^{upd_pc_i[63:MW+2], upd_pc_i[1:0]};

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_pht_q[r_wp]   <= upd_pc_i[PHT_IDX_W+1:2];
      r_bht_q[r_wp]   <= upd_pc_i[BHT_IDX_W+1:2];
      r_dir_q[r_wp]   <= upd_brdir_i;
      r_chwe_q[r_wp]  <= upd_ch_we_i;
      r_chdir_q[r_wp] <= upd_ch_brdir_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_INIT;
      r_init_idx     <= '0;
      r_init_done    <= 1'b0;
      r_wp           <= '0;
      r_rp           <= '0;
      r_cnt          <= '0;
      tbl_we_o       <= 1'b0;
      tbl_init_o     <= 1'b0;
      pht_wt_index_o <= '0;
      bht_wt_index_o <= '0;
      bht_brdir_o    <= 1'b0;
      ch_we_o        <= 1'b0;
      ch_brdir_o     <= 1'b0;
    end else if (init_start_i) begin
      r_state     <= S_INIT;
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      tbl_we_o    <= 1'b0;
      tbl_init_o  <= 1'b0;
      ch_we_o     <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt       <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_init_done <= (r_state == S_RUN);
      case (r_state)
        S_INIT: begin
          tbl_we_o       <= 1'b1;
          tbl_init_o     <= 1'b1;
          ch_we_o        <= 1'b0;
          bht_brdir_o    <= 1'b0;
          ch_brdir_o     <= 1'b0;
          pht_wt_index_o <= r_init_idx[PHT_IDX_W-1:0];
          bht_wt_index_o <= r_init_idx[BHT_IDX_W-1:0];
          if (r_init_idx == LAST_IDX) begin
            r_state    <= S_RUN;
            r_init_idx <= '0;
          end else begin
            r_init_idx <= r_init_idx + 1'b1;
          end
        end
        default: begin
          tbl_we_o   <= w_pop;
          tbl_init_o <= 1'b0;
          ch_we_o    <= w_pop && r_chwe_q[r_rp];
          if (w_pop) begin
            pht_wt_index_o <= r_pht_q[r_rp];
            bht_wt_index_o <= r_bht_q[r_rp];
            bht_brdir_o    <= r_dir_q[r_rp];
            ch_brdir_o     <= r_dir_q[r_rp] ^ r_chdir_q[r_rp];
          end
        end
      endcase
    end
  end
endmodule
